// File: rtl/pwm_fade_ctrl.sv
// Fade/breathe controller: ramps a linear brightness level one LSB per step interval,
// squares it for gamma and hands the compare word to the PWM generator on period boundaries.
//
// state   | meaning
// IDLE    | level holding, waiting for a command
// RAMP    | stepping toward target, done pulse on arrival
// BR_UP   | breathing, counting up toward target
// BR_DOWN | breathing, counting down toward 0
module pwm_fade_ctrl #(
  parameter int LEVEL_W = 8,
  parameter int CMP_W   = 16,
  parameter int DIV_W   = 18
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               period_end,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LEVEL_W-1:0] cmd_target,
  input  logic [DIV_W-1:0]   cmd_div,
  input  logic               cmd_breathe,
  output logic [CMP_W-1:0]   pwm_compare,
  output logic [LEVEL_W-1:0] level,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RAMP, BR_UP, BR_DOWN} state_t;

  state_t                 state, state_nxt;
  logic [LEVEL_W-1:0]     level_nxt;
  logic [LEVEL_W-1:0]     tgt;
  logic [DIV_W-1:0]       div_eff;
  logic [DIV_W-1:0]       cnt;
  logic                   accept;
  logic                   step;
  logic                   done_nxt;
  logic [2*LEVEL_W-1:0]   sq;
  logic [CMP_W-1:0]       shadow;

  assign cmd_ready = (state != RAMP);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  // an accept restarts the interval, so it always wins over a coincident step
  assign step      = busy && !accept && (cnt == div_eff - DIV_W'(1));
  assign sq        = {{LEVEL_W{1'b0}}, level} * {{LEVEL_W{1'b0}}, level};

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    done_nxt  = 1'b0;
    if (accept) begin
      if (!cmd_breathe || cmd_target == '0) begin
        if (cmd_target == level) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = RAMP;
        end
      end else if (level < cmd_target) begin
        state_nxt = BR_UP;
      end else begin
        state_nxt = BR_DOWN;
      end
    end else if (step) begin
      case (state)
        RAMP: begin
          level_nxt = (level < tgt) ? level + LEVEL_W'(1) : level - LEVEL_W'(1);
          if (level_nxt == tgt) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        BR_UP: begin
          if (level != '1) level_nxt = level + LEVEL_W'(1);
          if (level_nxt >= tgt) state_nxt = BR_DOWN;
        end
        BR_DOWN: begin
          if (level != '0) level_nxt = level - LEVEL_W'(1);
          if (level_nxt == '0) state_nxt = BR_UP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      level   <= '0;
      tgt     <= '0;
      div_eff <= DIV_W'(1);
      cnt     <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      done  <= done_nxt;
      if (accept) begin
        tgt     <= cmd_target;
        div_eff <= (cmd_div == '0) ? DIV_W'(1) : cmd_div;
        cnt     <= '0;
      end else if (busy) begin
        cnt <= step ? '0 : cnt + DIV_W'(1);
      end
    end
  end

  // compare word only moves on period_end so the PWM never sees a mid-period change
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow      <= '0;
      pwm_compare <= '0;
    end else begin
      shadow <= sq[2*LEVEL_W-1 -: CMP_W];
      if (period_end) pwm_compare <= shadow;
    end
  end

endmodule
